// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DMEM_WORD_BYTES = 4;

  function automatic int index_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: one read or one write per edge, registered read data, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = index_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read data only moves on a read access, so it holds through backpressure.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response with WAIT_STATES wait cycles.
// Optional address checking is enabled with `define DMEM_BOUNDS_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output state_t            state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the initiator holds req_* stable while req_valid waits, and the responder
  // holds resp_* stable while resp_valid waits for resp_ready.

  localparam int         IDX_W     = index_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              accept;
  logic              access_en;
  logic              addr_err;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_write;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [31:0]       ram_rdata;

  assign accept = (state_q == IDLE) && req_valid;
  assign state  = state_q;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (|(req_addr >> (IDX_W + 2)));
  assign resp_err = (state_q == RESP) && err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
  assign addr_err = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    access_en  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d   = RESP;
            access_en = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          access_en = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= WAIT_LOAD;
        idx_q   <= req_addr[IDX_W+1:2];
        write_q <= req_write;
        wdata_q <= req_wdata;
        err_q   <= addr_err;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // With zero wait states the access shares the accept edge, so it uses the live request.
  assign acc_idx   = (state_q == IDLE) ? req_addr[IDX_W+1:2] : idx_q;
  assign acc_write = (state_q == IDLE) ? req_write : write_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_err   = (state_q == IDLE) ? addr_err  : err_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (Clk),
    .en    (access_en && !acc_err),
    .we    (acc_write),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign resp_rdata = (state_q == RESP && !write_q && !err_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a cycle-level reference model and per-cycle compare.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          busy;
  state_t        dut_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .ADDR_W      (AW)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .state      (dut_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_phase: 0 = free, 1 = request outstanding, 2 = response offered
  int          m_phase = 0;
  longint      cyc     = 0;
  longint      m_acc   = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_write, m_err;
  logic [31:0] m_mem [int];

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (a >= DEPTH * 4);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  task model_access();
    int idx;
    idx   = int'((m_addr / 4) % DEPTH);
    m_err = addr_bad(m_addr);
    if (m_err) begin
      m_rdata = 32'd0;
    end else if (m_write) begin
      m_mem[idx] = m_wdata;
      m_rdata    = 32'd0;
    end else begin
      m_rdata = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx;
    end
    m_phase = 2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      cyc++;
      case (m_phase)
        0: if (req_valid) begin
          m_addr  = req_addr;
          m_write = req_write;
          m_wdata = req_wdata;
          m_acc   = cyc;
          m_phase = 1;
          if (WS == 0) model_access();
        end
        1: if (cyc == m_acc + WS) model_access();
        2: if (resp_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_req_ready", 32'(req_ready), 32'(m_phase == 0));
    check("cyc_busy", 32'(busy), 32'(m_phase != 0));
    check("cyc_resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check("cyc_resp_rdata", resp_rdata, m_rdata);
      check("cyc_resp_err", 32'(resp_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit poke,
                     input logic [31:0] exp_d, input logic exp_e);
    int lat;
    logic [31:0] want;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = 1'b0;
    exp_q.push_back(exp_d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 32) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      errors++;
      checks++;
      $display("FAIL resp_timeout: actual=no resp_valid required=resp_valid within 32 edges");
    end
    check("latency", 32'(lat), 32'(WS + 1));
    want = exp_q.pop_front();
    check("resp_rdata", resp_rdata, want);
    check("resp_err", 32'(resp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0BAD_0BAD;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("held_valid", 32'(resp_valid), 32'd1);
      check("held_rdata", resp_rdata, want);
      check("held_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // Launches a request and returns once it is accepted, leaving the response unconsumed.
  task automatic launch(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Store/load round trip, then backpressure with an ignored request pulse.
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 32'h10, 32'h0,         5, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 32'h10, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Reset during the wait phase discards the store.
    txn(1'b1, 32'h20, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    launch(1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0, 1'b0);

    // Reset while a response is offered: valid drops at once, the store stays committed.
    launch(1'b1, 32'h30, 32'hCAFE_F00D);
    n = 0;
    while (!resp_valid && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h30, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);

`ifdef DMEM_BOUNDS_CHECK_EN
    txn(1'b1, 32'h000, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b0);
    txn(1'b0, 32'h402, 32'h0,         0, 1'b0, 32'h0, 1'b1);
    txn(1'b1, 32'h400, 32'h2222_2222, 0, 1'b0, 32'h0, 1'b1);
    txn(1'b0, 32'h013, 32'h0,         0, 1'b0, 32'h0, 1'b1);
    txn(1'b0, 32'h000, 32'h0,         0, 1'b0, 32'h1111_1111, 1'b0);
`else
    txn(1'b1, 32'h404, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, 1'b0);
    txn(1'b0, 32'h004, 32'h0,         0, 1'b0, 32'hA5A5_A5A5, 1'b0);
    txn(1'b0, 32'h013, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 32'hFFFF_FC10, 32'h0,   0, 1'b0, 32'hDEAD_BEEF, 1'b0);
`endif

    // Back-to-back stores across the top of the array, then read them back.
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 32'h3F0 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1), 0, 1'b0, 32'h0, 1'b0);
    end
    for (int i = 3; i >= 0; i--) begin
      txn(1'b0, 32'h3F0 + 32'(4 * i), 32'h0, 1, 1'b0, 32'h0101_0101 * 32'(i + 1), 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
